// File: rtl/r512x16_arb_pkg.sv
// Shared sizing, byte-enable width and controller state encoding for the
// dual-requester RAM arbiter.
package r512x16_arb_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 512;
    localparam int BE_W   = 2;

    typedef enum logic {
        CLEAR,
        RUN
    } arb_state_t;

endpackage

// File: rtl/r512x16_arbiter_rr_arb2.sv
// Two-way round-robin grant logic; the pointer remembers the last winner and
// resets to requester 1 so that requester 0 wins the first tie.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o  = '0;
        last_d = last_q;
        if (en_i) begin
            if (req_i[0] && (!req_i[1] || last_q)) begin
                gnt_o[0] = 1'b1;
                last_d   = 1'b0;
            end else if (req_i[1]) begin
                gnt_o[1] = 1'b1;
                last_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/r512x16_arbiter.sv
// Two-requester arbiter in front of a registered-read 512x16 byte-writable RAM.
// Define R512X16_ARB_CLEAR_EN to zero the whole RAM after every reset release.
module r512x16_arbiter
    import r512x16_arb_pkg::*;
#(
    parameter int ADDR_W = r512x16_arb_pkg::ADDR_W,
    parameter int DATA_W = r512x16_arb_pkg::DATA_W,
    parameter int DEPTH  = r512x16_arb_pkg::DEPTH
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              Wr0,
    input  logic              Wr1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WD0,
    input  logic [DATA_W-1:0] WD1,
    input  logic [BE_W-1:0]   BE0,
    input  logic [BE_W-1:0]   BE1,
    output logic              Ack0,
    output logic              Ack1,
    output logic              RValid0,
    output logic              RValid1,
    output logic [DATA_W-1:0] RD,
    output logic              Busy,
    output logic [ADDR_W-1:0] WA,
    output logic [DATA_W-1:0] WD,
    output logic [BE_W-1:0]   WEN,
    output logic              WClk_En,
    output logic [ADDR_W-1:0] RA,
    output logic              RClk_En,
    input  logic [DATA_W-1:0] RamRD
);

    logic [1:0]        gnt;
    logic              busy;
    logic              rvalid0_q, rvalid1_q;
    logic [ADDR_W-1:0] ra_q, ra_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [BE_W-1:0]   wen_d;

`ifdef R512X16_ARB_CLEAR_EN
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == CLR_LAST) begin
                state_d   = RUN;
                clr_cnt_d = '0;
            end
        end
    end

    assign busy = (state_q == CLEAR);
`else
    assign busy = 1'b0;
`endif

    // Reset gates the enable so Ack/WEN stay low for the whole reset window.
    rr_arb2 u_rr (
        .clk_i  (Clk),
        .rst_ni (Rst_n),
        .en_i   (Rst_n & ~busy),
        .req_i  ({Req1, Req0}),
        .gnt_o  (gnt)
    );

    // RA/WA/WD fall back to their registered copies so idle cycles hold them.
    always_comb begin
        ra_d  = ra_q;
        wa_d  = wa_q;
        wd_d  = wd_q;
        wen_d = '0;
        if (gnt[0]) begin
            if (Wr0) begin
                wa_d  = Addr0;
                wd_d  = WD0;
                wen_d = BE0;
            end else begin
                ra_d = Addr0;
            end
        end else if (gnt[1]) begin
            if (Wr1) begin
                wa_d  = Addr1;
                wd_d  = WD1;
                wen_d = BE1;
            end else begin
                ra_d = Addr1;
            end
        end
`ifdef R512X16_ARB_CLEAR_EN
        if (Rst_n && (state_q == CLEAR)) begin
            wa_d  = clr_cnt_q;
            wd_d  = '0;
            wen_d = '1;
        end
`endif
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ra_q      <= '0;
            wa_q      <= '0;
            wd_q      <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            ra_q      <= ra_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            rvalid0_q <= gnt[0] & ~Wr0;
            rvalid1_q <= gnt[1] & ~Wr1;
        end
    end

    assign Ack0    = gnt[0];
    assign Ack1    = gnt[1];
    assign RValid0 = rvalid0_q;
    assign RValid1 = rvalid1_q;
    assign RD      = RamRD;
    assign Busy    = busy;
    assign WA      = wa_d;
    assign WD      = wd_d;
    assign WEN     = wen_d;
    assign RA      = ra_d;
    assign WClk_En = 1'b1;
    assign RClk_En = 1'b1;

endmodule

// File: tb/tb_r512x16_arbiter.sv
// Directed bench for r512x16_arbiter with a behavioural RAM, a shadow memory
// and per-requester read-data scoreboards; covers R512X16_ARB_CLEAR_EN builds.
module tb_r512x16_arbiter;

    typedef struct {
        logic [15:0] d;
        int          c;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Req0, Req1, Wr0, Wr1;
    logic [8:0]  Addr0, Addr1;
    logic [15:0] WD0, WD1;
    logic [1:0]  BE0, BE1;
    logic        Ack0, Ack1, RValid0, RValid1, Busy, WClk_En, RClk_En;
    logic [15:0] RD, WD, RamRD;
    logic [8:0]  WA, RA;
    logic [1:0]  WEN;

    logic [15:0] ram    [512] = '{default: 16'hDEAD};
    logic [15:0] shadow [512] = '{default: 16'hDEAD};
    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always #5 Clk = ~Clk;

    r512x16_arbiter #(.ADDR_W(9), .DATA_W(16), .DEPTH(512)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
        .Addr0(Addr0), .Addr1(Addr1), .WD0(WD0), .WD1(WD1),
        .BE0(BE0), .BE1(BE1),
        .Ack0(Ack0), .Ack1(Ack1), .RValid0(RValid0), .RValid1(RValid1),
        .RD(RD), .Busy(Busy),
        .WA(WA), .WD(WD), .WEN(WEN), .WClk_En(WClk_En),
        .RA(RA), .RClk_En(RClk_En), .RamRD(RamRD)
    );

    always @(posedge Clk) begin
        if (WClk_En && WEN[0]) ram[WA][7:0]  <= WD[7:0];
        if (WClk_En && WEN[1]) ram[WA][15:8] <= WD[15:8];
        if (RClk_En) RamRD <= ram[RA];
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Read data is due exactly one cycle after the grant it was pushed for.
    always @(negedge Clk) begin
        exp_t e;
        if (q0.size() > 0 && q0[0].c + 1 <= cyc) begin
            e = q0.pop_front();
            chk("rvalid0", {31'd0, RValid0}, 1);
            chk("rd0", {16'd0, RD}, {16'd0, e.d});
        end else if (RValid0 !== 1'b0) begin
            chk("rvalid0_spurious", {31'd0, RValid0}, 0);
        end
        if (q1.size() > 0 && q1[0].c + 1 <= cyc) begin
            e = q1.pop_front();
            chk("rvalid1", {31'd0, RValid1}, 1);
            chk("rd1", {16'd0, RD}, {16'd0, e.d});
        end else if (RValid1 !== 1'b0) begin
            chk("rvalid1_spurious", {31'd0, RValid1}, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wr_shadow(input logic [8:0] a, input logic [15:0] d, input logic [1:0] b);
        if (b[0]) shadow[a][7:0]  = d[7:0];
        if (b[1]) shadow[a][15:8] = d[15:8];
    endtask

    task automatic step(input string tag,
                        input logic r0, input logic w0, input logic [8:0] a0,
                        input logic [15:0] d0, input logic [1:0] b0,
                        input logic r1, input logic w1, input logic [8:0] a1,
                        input logic [15:0] d1, input logic [1:0] b1,
                        input logic e0, input logic e1);
        logic [1:0] ewen;
        Req0 = r0; Wr0 = w0; Addr0 = a0; WD0 = d0; BE0 = b0;
        Req1 = r1; Wr1 = w1; Addr1 = a1; WD1 = d1; BE1 = b1;
        @(negedge Clk);
        chk({tag, "_ack0"}, {31'd0, Ack0}, {31'd0, e0});
        chk({tag, "_ack1"}, {31'd0, Ack1}, {31'd0, e1});
        ewen = 2'b00;
        if (e0 && w0) ewen = b0;
        if (e1 && w1) ewen = b1;
        chk({tag, "_wen"}, {30'd0, WEN}, {30'd0, ewen});
        if (e0) begin
            if (w0) begin
                chk({tag, "_wa"}, {23'd0, WA}, {23'd0, a0});
                chk({tag, "_wd"}, {16'd0, WD}, {16'd0, d0});
                wr_shadow(a0, d0, b0);
            end else begin
                chk({tag, "_ra"}, {23'd0, RA}, {23'd0, a0});
                q0.push_back('{shadow[a0], cyc});
            end
        end
        if (e1) begin
            if (w1) begin
                chk({tag, "_wa"}, {23'd0, WA}, {23'd0, a1});
                chk({tag, "_wd"}, {16'd0, WD}, {16'd0, d1});
                wr_shadow(a1, d1, b1);
            end else begin
                chk({tag, "_ra"}, {23'd0, RA}, {23'd0, a1});
                q1.push_back('{shadow[a1], cyc});
            end
        end
        @(posedge Clk); #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 9'h0, 16'h0, 2'b00, 0, 0, 9'h0, 16'h0, 2'b00, 0, 0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (n < 600 && Busy !== 1'b0) begin
            @(negedge Clk);
            n++;
        end
        chk("ready_busy", {31'd0, Busy}, 0);
`ifdef R512X16_ARB_CLEAR_EN
        for (int i = 0; i < 512; i++) shadow[i] = 16'h0000;
`endif
        @(posedge Clk); #1;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        q0.delete();
        q1.delete();
        Req0 = 1'b1; Wr0 = 1'b0; Req1 = 1'b1; Wr1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("rst_ack0", {31'd0, Ack0}, 0);
            chk("rst_ack1", {31'd0, Ack1}, 0);
            chk("rst_rvalid1", {31'd0, RValid1}, 0);
            chk("rst_wen", {30'd0, WEN}, 0);
        end
        Req0 = 1'b0; Req1 = 1'b0;
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        wait_ready();
    endtask

    initial begin
        int busy_cycles;
        Rst_n = 1'b0;
        Req0 = 1'b1; Wr0 = 1'b0; Addr0 = 9'h1FF; WD0 = '0; BE0 = '0;
        Req1 = 1'b1; Wr1 = 1'b0; Addr1 = 9'h000; WD1 = '0; BE1 = '0;
        repeat (2) @(negedge Clk);
        chk("rst0_ack0", {31'd0, Ack0}, 0);
        chk("rst0_ack1", {31'd0, Ack1}, 0);
        chk("rst0_rvalid0", {31'd0, RValid0}, 0);
        chk("rst0_wen", {30'd0, WEN}, 0);
        chk("wclk_en", {31'd0, WClk_En}, 1);
        chk("rclk_en", {31'd0, RClk_En}, 1);
        @(posedge Clk); #1;
        Req1 = 1'b0;
`ifdef R512X16_ARB_CLEAR_EN
        Rst_n = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge Clk);
            if (Busy !== 1'b1) break;
            busy_cycles++;
            chk("clear_ack0", {31'd0, Ack0}, 0);
            chk("clear_wen", {30'd0, WEN}, 2'b11);
        end
        chk("clear_busy_cycles", busy_cycles, 512);
        chk("clear_ack0_after", {31'd0, Ack0}, 1);
        chk("clear_ra", {23'd0, RA}, 32'h1FF);
        q0.push_back('{16'h0000, cyc});
        for (int i = 0; i < 512; i++) shadow[i] = 16'h0000;
        @(posedge Clk); #1;
        Req0 = 1'b0;
`else
        busy_cycles = 0;
        Req0 = 1'b0;
        Rst_n = 1'b1;
        wait_ready();
`endif

        // single word write then read-back
        step("w005", 1, 1, 9'h005, 16'hA5C3, 2'b11, 0, 0, 9'h0, 16'h0, 2'b00, 1, 0);
        step("r005", 1, 0, 9'h005, 16'h0000, 2'b00, 0, 0, 9'h0, 16'h0, 2'b00, 1, 0);
        idle("i1");

        // byte lanes, then a write with no lanes enabled
        step("w010a", 1, 1, 9'h010, 16'h1234, 2'b01, 0, 0, 9'h0, 16'h0, 2'b00, 1, 0);
        step("w010b", 1, 1, 9'h010, 16'hABCD, 2'b10, 0, 0, 9'h0, 16'h0, 2'b00, 1, 0);
        step("w010z", 1, 1, 9'h010, 16'hFFFF, 2'b00, 0, 0, 9'h0, 16'h0, 2'b00, 1, 0);
        step("r010",  1, 0, 9'h010, 16'h0000, 2'b00, 0, 0, 9'h0, 16'h0, 2'b00, 1, 0);
        idle("i2");
        chk("byte_merge", {16'd0, shadow[9'h010]}, (busy_cycles == 0) ? 32'hAB34 : 32'hAB34);

        // back-to-back mixed traffic, ends with a requester-0 grant
        step("w1_020", 0, 0, 9'h0, 16'h0, 2'b00, 1, 1, 9'h020, 16'h1111, 2'b11, 0, 1);
        step("r0_010", 1, 0, 9'h010, 16'h0, 2'b00, 0, 0, 9'h0, 16'h0, 2'b00, 1, 0);
        step("r1_020", 0, 0, 9'h0, 16'h0, 2'b00, 1, 0, 9'h020, 16'h0, 2'b00, 0, 1);
        step("w0_005", 1, 1, 9'h005, 16'h5A5A, 2'b11, 0, 0, 9'h0, 16'h0, 2'b00, 1, 0);
        idle("i3");

        // pointer must return to "last = 1" even though requester 0 won last
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step("tie_w", 1, 1, 9'(9'h040 + i), 16'(16'h4000 + i), 2'b11,
                          1, 1, 9'(9'h060 + i), 16'(16'h6000 + i), 2'b11,
                          (i % 2) == 0, (i % 2) == 1);
        end
        for (int i = 0; i < 4; i++) begin
            step("tie_r", 1, 0, 9'h040, 16'h0, 2'b00, 1, 0, 9'h061, 16'h0, 2'b00,
                          (i % 2) == 0, (i % 2) == 1);
        end
        idle("i4");

        // reset in the cycle after a read grant kills the pending RValid1
        step("r1_061", 0, 0, 9'h0, 16'h0, 2'b00, 1, 0, 9'h061, 16'h0, 2'b00, 0, 1);
        do_reset();
        step("post_rst_tie", 1, 0, 9'h040, 16'h0, 2'b00, 1, 0, 9'h061, 16'h0, 2'b00, 1, 0);
        step("r1_alone", 0, 0, 9'h0, 16'h0, 2'b00, 1, 0, 9'h061, 16'h0, 2'b00, 0, 1);
        idle("i5");
        idle("i6");

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/r512x16_arbiter.md
R512X16_ARBITER -- requirements
Module: r512x16_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning RAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning RAM data width.
REQ-003 SHALL have parameter DEPTH, default 512, meaning RAM word count.
REQ-004 SHALL have port Clk, input, 1, meaning the single clock; all logic on posedge Clk.
REQ-005 SHALL have port Rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have ports Req0/Req1, input, 1, meaning the requester holds an access request.
REQ-007 SHALL have ports Wr0/Wr1, input, 1, meaning 1 = write, 0 = read.
REQ-008 SHALL have ports Addr0/Addr1, input, ADDR_W, meaning word address.
REQ-009 SHALL have ports WD0/WD1, input, DATA_W, meaning write data.
REQ-010 SHALL have ports BE0/BE1, input, 2, meaning byte enables; [0] = bits 7:0, [1] = bits 15:8.
REQ-011 SHALL have ports Ack0/Ack1, output, 1, meaning the request is issued to the RAM this cycle.
REQ-012 SHALL have ports RValid0/RValid1, output, 1, meaning RD holds this requester's read data.
REQ-013 SHALL have port RD, output, DATA_W, meaning read data shared by both requesters.
REQ-014 SHALL have port Busy, output, 1, meaning the arbiter is not accepting requests.
REQ-015 SHALL have RAM-side outputs WA (ADDR_W), WD (DATA_W), WEN (2), WClk_En (1), RA (ADDR_W) and RClk_En (1).
REQ-016 SHALL have RAM-side input RamRD, DATA_W, registered RAM read data with 1-cycle latency.

Function
REQ-017 SHALL grant at most one requester per cycle, only when Busy = 0.
REQ-018 SHALL arbitrate round-robin: a lone requester wins; on a tie the requester not granted most recently wins.
REQ-019 SHALL drive Ackn combinationally high in the grant cycle; the requester may change its inputs in the next cycle.
REQ-020 SHALL, on a write grant, drive WA = Addrn, WD = WDn and WEN = BEn that cycle, with WEN = 0 in all other cycles.
REQ-021 SHALL Ack a write with BEn = 00 and leave memory unchanged.
REQ-022 SHALL, on a read grant, drive RA = Addrn that cycle and pulse RValidn high for exactly the next cycle, with RD = RamRD.
REQ-023 SHALL support back-to-back grants every cycle, including alternating read/write, with no bubble.
REQ-024 SHALL tie WClk_En and RClk_En to 1.
REQ-025 SHALL hold RA and WA at their last values when idle; only WEN gates writes.

Reset
REQ-026 SHALL, while Rst_n = 0, force Ack0/1 = 0, RValid0/1 = 0, WEN = 0 and the round-robin pointer to "last = 1", so requester 0 wins the first tie.
REQ-027 SHALL, on reset asserted mid-operation, immediately drop any pending RValid and abort any clear sequence, restarting it after release.
REQ-028 SHALL NOT alter RAM contents through reset itself.

Configuration
REQ-029 SHALL, with R512X16_ARB_CLEAR_EN defined, enter state CLEAR after reset and write 0 with WEN = 11 to addresses 0..DEPTH-1, one per cycle.
REQ-030 SHALL, in CLEAR, hold Busy = 1 and Ack = 0, then move to state RUN after address DEPTH-1 (DEPTH cycles) and deassert Busy.
REQ-031 SHALL, without R512X16_ARB_CLEAR_EN, start in RUN, tie Busy to 0, and omit the clear counter.

Structure
REQ-032 SHALL take ADDR_W, DATA_W, DEPTH, BE_W = 2 and the state enum {CLEAR, RUN} from shared package r512x16_arb_pkg.
REQ-033 SHALL place the two-way round-robin grant logic and its pointer register in sub-module rr_arb2.

Verification
REQ-034 SHALL cover a single write: Req0 with Wr0 = 1, Addr0 = 0x005, WD0 = 0xA5C3, BE0 = 11; then Req0 read of 0x005. Required: Ack0 in the same cycle as each request, and RValid0 = 1 with RD = 0xA5C3 the cycle after the read Ack.
REQ-035 SHALL cover byte writes: write 0x1234 to 0x010 with BE = 01, then 0xABCD to 0x010 with BE = 10, then read 0x010. Required: RD = 0xAB34.
REQ-036 SHALL cover contention: Req0 and Req1 held high continuously from just after reset. Required: grants alternate 0, 1, 0, 1, with exactly one Ack per cycle.
REQ-037 SHALL cover the clear feature with R512X16_ARB_CLEAR_EN defined: after reset release, Busy = 1 for 512 cycles with Req0 held and no Ack0. Then a read of 0x1FF returns 0x0000.
REQ-038 SHALL cover reset mid-operation: assert Rst_n = 0 in the cycle after a read Ack1. Required: RValid1 is never asserted and the first tie after release goes to requester 0.
